// File: rtl/branch_target_predictor.sv
// Fully associative branch target buffer with per-entry saturating counters.
// Optional lookup hit/miss statistics are enabled with BTB_PERF_CNT_EN.

package maverickOne_pkg;
   parameter int unsigned NUM_BTBL = 4;
   parameter int unsigned XLEN     = 32;
endpackage

module branch_target_predictor #(
   parameter int unsigned NUM_BTBL = maverickOne_pkg::NUM_BTBL,
   parameter int unsigned XLEN     = maverickOne_pkg::XLEN,
   parameter int unsigned CNT_W    = 2
) (
   input  logic            clk_i,
   input  logic            arst_ni,
   input  logic            lookup_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            upd_taken_i,
   input  logic            invalidate_all_i,
   output logic            hit_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o
`ifdef BTB_PERF_CNT_EN
   ,
   output logic [31:0]     hit_count_o,
   output logic [31:0]     miss_count_o
`endif
);

   localparam int unsigned IdxW = $clog2(NUM_BTBL);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntInit = CNT_W'(1) << (CNT_W - 1);

   logic [NUM_BTBL-1:0] valid_q;
   logic [CNT_W-1:0]    cnt_q [NUM_BTBL];
   logic [IdxW-1:0]     ptr_q;
   logic [XLEN-1:2]     tag_mem [NUM_BTBL];
   logic [XLEN-1:2]     target_mem [NUM_BTBL];

   logic            lk_hit, up_hit, free_any;
   logic [IdxW-1:0] lk_idx, up_idx, free_idx, alloc_idx;
   logic            lk_taken;
   logic            unused_bits;

   assign unused_bits = ^{upd_pc_i[1:0], upd_target_i[1:0]};

   // Descending scans so the lowest matching / free index wins.
   always_comb begin
      lk_hit   = 1'b0;
      lk_idx   = '0;
      up_hit   = 1'b0;
      up_idx   = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int i = int'(NUM_BTBL) - 1; i >= 0; i--) begin
         if (valid_q[i] && tag_mem[i] == pc_i[XLEN-1:2]) begin
            lk_hit = 1'b1;
            lk_idx = IdxW'(i);
         end
         if (valid_q[i] && tag_mem[i] == upd_pc_i[XLEN-1:2]) begin
            up_hit = 1'b1;
            up_idx = IdxW'(i);
         end
         if (!valid_q[i]) begin
            free_any = 1'b1;
            free_idx = IdxW'(i);
         end
      end
   end

   assign alloc_idx = free_any ? free_idx : ptr_q;
   assign lk_taken  = lookup_i && lk_hit && cnt_q[lk_idx][CNT_W-1];

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         valid_q <= '0;
         cnt_q   <= '{default: '0};
         ptr_q   <= '0;
      end else if (invalidate_all_i) begin
         valid_q <= '0;
         ptr_q   <= '0;
      end else if (upd_valid_i) begin
         if (up_hit) begin
            if (upd_taken_i) begin
               if (cnt_q[up_idx] != CntMax) cnt_q[up_idx] <= cnt_q[up_idx] + CNT_W'(1);
            end else if (cnt_q[up_idx] == '0) begin
               valid_q[up_idx] <= 1'b0;
            end else begin
               cnt_q[up_idx] <= cnt_q[up_idx] - CNT_W'(1);
            end
         end else if (upd_taken_i) begin
            valid_q[alloc_idx] <= 1'b1;
            cnt_q[alloc_idx]   <= CntInit;
            if (!free_any) ptr_q <= ptr_q + IdxW'(1);
         end
      end
   end

   // Tag/target storage has no reset; valid bits alone define table contents.
   always_ff @(posedge clk_i) begin
      if (!invalidate_all_i && upd_valid_i && upd_taken_i) begin
         if (up_hit) begin
            target_mem[up_idx] <= upd_target_i[XLEN-1:2];
         end else begin
            tag_mem[alloc_idx]    <= upd_pc_i[XLEN-1:2];
            target_mem[alloc_idx] <= upd_target_i[XLEN-1:2];
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         hit_o         <= 1'b0;
         pred_taken_o  <= 1'b0;
         pred_target_o <= '0;
      end else begin
         hit_o         <= lookup_i && lk_hit;
         pred_taken_o  <= lk_taken;
         pred_target_o <= lk_taken ? {target_mem[lk_idx], 2'b00} : pc_i + XLEN'(4);
      end
   end

`ifdef BTB_PERF_CNT_EN
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else if (invalidate_all_i) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else if (lookup_i) begin
         if (lk_hit) hit_count_o <= hit_count_o + 32'd1;
         else        miss_count_o <= miss_count_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed vector table,
// reset corner cases and randomized traffic against a behavioural model.

module tb_branch_target_predictor;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        lookup;
   logic [31:0] pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        inv_all;
   logic        hit;
   logic        pred_taken;
   logic [31:0] pred_target;
`ifdef BTB_PERF_CNT_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   always #5 clk = ~clk;

   branch_target_predictor #(
      .NUM_BTBL(4),
      .XLEN    (32),
      .CNT_W   (2)
   ) dut (
      .clk_i           (clk),
      .arst_ni         (arst_n),
      .lookup_i        (lookup),
      .pc_i            (pc),
      .upd_valid_i     (upd_valid),
      .upd_pc_i        (upd_pc),
      .upd_target_i    (upd_target),
      .upd_taken_i     (upd_taken),
      .invalidate_all_i(inv_all),
      .hit_o           (hit),
      .pred_taken_o    (pred_taken),
      .pred_target_o   (pred_target)
`ifdef BTB_PERF_CNT_EN
      ,
      .hit_count_o     (hit_count),
      .miss_count_o    (miss_count)
`endif
   );

   typedef struct {
      logic        lk;
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic        ut;
      logic        inv;
      logic        eh;
      logic        et;
      logic [31:0] etg;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: a list of entries, plain integer counters.
   bit          m_valid [N];
   logic [29:0] m_tag   [N];
   logic [29:0] m_tgt   [N];
   int          m_cnt   [N];
   int          m_ptr;
   int unsigned m_hits, m_miss;
   logic        e_hit, e_taken;
   logic [31:0] e_tgt;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_cnt[i]   = 0;
      end
      m_ptr  = 0;
      m_hits = 0;
      m_miss = 0;
   endfunction

   function automatic void model_step(logic lk, logic [31:0] a, logic uv, logic [31:0] ua,
                                      logic [31:0] ut_addr, logic ut, logic inv);
      int h = -1;
      int u = -1;
      int f = -1;
      for (int i = 0; i < N; i++)
         if (h < 0 && m_valid[i] && m_tag[i] == a[31:2]) h = i;
      e_hit   = lk && (h >= 0);
      e_taken = e_hit && (m_cnt[h] >= 2);
      e_tgt   = e_taken ? {m_tgt[h], 2'b00} : a + 32'd4;
      if (inv) begin
         for (int i = 0; i < N; i++) m_valid[i] = 0;
         m_ptr  = 0;
         m_hits = 0;
         m_miss = 0;
         return;
      end
      if (lk) begin
         if (h >= 0) m_hits++;
         else        m_miss++;
      end
      if (!uv) return;
      for (int i = 0; i < N; i++)
         if (u < 0 && m_valid[i] && m_tag[i] == ua[31:2]) u = i;
      if (u >= 0) begin
         if (ut) begin
            m_cnt[u] = (m_cnt[u] + 1 > 3) ? 3 : m_cnt[u] + 1;
            m_tgt[u] = ut_addr[31:2];
         end else if (m_cnt[u] == 0) begin
            m_valid[u] = 0;
         end else begin
            m_cnt[u] = m_cnt[u] - 1;
         end
      end else if (ut) begin
         for (int i = 0; i < N; i++)
            if (f < 0 && !m_valid[i]) f = i;
         if (f < 0) begin
            f     = m_ptr;
            m_ptr = (m_ptr + 1) % N;
         end
         m_valid[f] = 1;
         m_tag[f]   = ua[31:2];
         m_tgt[f]   = ut_addr[31:2];
         m_cnt[f]   = 2;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic lk, input logic [31:0] a, input logic uv,
                        input logic [31:0] ua, input logic [31:0] tg, input logic ut,
                        input logic inv);
      @(negedge clk);
      lookup     = lk;
      pc         = a;
      upd_valid  = uv;
      upd_pc     = ua;
      upd_target = tg;
      upd_taken  = ut;
      inv_all    = inv;
      @(posedge clk);
      model_step(lk, a, uv, ua, tg, ut, inv);
      #1;
`ifdef BTB_PERF_CNT_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_miss);
`endif
   endtask

   function automatic void add(logic lk, logic [31:0] a, logic uv, logic [31:0] ua,
                               logic [31:0] tg, logic ut, logic inv,
                               logic eh, logic et, logic [31:0] etg);
      vec_t v;
      v.lk = lk; v.pc = a; v.uv = uv; v.upc = ua; v.utgt = tg; v.ut = ut; v.inv = inv;
      v.eh = eh; v.et = et; v.etg = etg;
      vecs.push_back(v);
   endfunction

   initial begin
      arst_n = 1'b0; lookup = 1'b0; pc = 32'h123; upd_valid = 1'b0; upd_pc = '0;
      upd_target = '0; upd_taken = 1'b0; inv_all = 1'b0;
      model_reset();

      add(1, 'h100, 0, 0, 0, 0, 0,           0, 0, 'h104);
      add(0, 'h100, 1, 'h100, 'h200, 1, 0,   0, 0, 'h104);
      add(1, 'h102, 0, 0, 0, 0, 0,           1, 1, 'h200);
      add(1, 'h102, 1, 'h100, 0, 0, 0,       1, 1, 'h200);
      add(1, 'h100, 1, 'h100, 0, 0, 0,       1, 0, 'h104);
      add(1, 'h100, 0, 0, 0, 0, 0,           1, 0, 'h104);
      add(1, 'h100, 1, 'h100, 0, 0, 0,       1, 0, 'h104);
      add(1, 'h100, 0, 0, 0, 0, 0,           0, 0, 'h104);
      add(0, 0, 1, 'h10, 'h1010, 1, 0,       0, 0, 'h4);
      add(0, 0, 1, 'h20, 'h2020, 1, 0,       0, 0, 'h4);
      add(0, 0, 1, 'h30, 'h3030, 1, 0,       0, 0, 'h4);
      add(0, 0, 1, 'h40, 'h4040, 1, 0,       0, 0, 'h4);
      add(0, 0, 1, 'h50, 'h5050, 1, 0,       0, 0, 'h4);
      add(1, 'h10, 0, 0, 0, 0, 0,            0, 0, 'h14);
      add(1, 'h50, 0, 0, 0, 0, 0,            1, 1, 'h5050);
      add(0, 0, 1, 'h60, 'h6060, 1, 0,       0, 0, 'h4);
      add(1, 'h20, 0, 0, 0, 0, 0,            0, 0, 'h24);
      add(1, 'h30, 0, 0, 0, 0, 0,            1, 1, 'h3030);
      add(1, 'h60, 0, 0, 0, 0, 0,            1, 1, 'h6060);
      add(1, 'h300, 1, 'h300, 'h703, 1, 0,   0, 0, 'h304);
      add(1, 'h301, 0, 0, 0, 0, 0,           1, 1, 'h700);
      add(0, 0, 1, 'h60, 'h6060, 1, 0,       0, 0, 'h4);
      add(0, 0, 1, 'h60, 'h6060, 1, 0,       0, 0, 'h4);
      add(0, 0, 1, 'h60, 0, 0, 0,            0, 0, 'h4);
      add(1, 'h60, 0, 0, 0, 0, 0,            1, 1, 'h6060);
      add(1, 'h60, 1, 'h60, 0, 0, 0,         1, 1, 'h6060);
      add(1, 'h60, 0, 0, 0, 0, 0,            1, 0, 'h64);
      add(1, 'h300, 1, 'h400, 'h900, 1, 1,   1, 1, 'h700);
      add(1, 'h100, 0, 0, 0, 0, 0,           0, 0, 'h104);
      add(1, 'h400, 0, 0, 0, 0, 0,           0, 0, 'h404);
      add(1, 'h300, 0, 0, 0, 0, 0,           0, 0, 'h304);
      add(1, 'hFFFF_FFFC, 0, 0, 0, 0, 0,     0, 0, 'h0);

      #12;
      check("reset hit", {31'd0, hit}, 0);
      check("reset pred_taken", {31'd0, pred_taken}, 0);
      check("reset pred_target", pred_target, 0);
      @(negedge clk);
      arst_n = 1'b1;

      foreach (vecs[k]) begin
         drive(vecs[k].lk, vecs[k].pc, vecs[k].uv, vecs[k].upc, vecs[k].utgt, vecs[k].ut,
               vecs[k].inv);
         check($sformatf("vec%0d hit", k), {31'd0, hit}, {31'd0, vecs[k].eh});
         check($sformatf("vec%0d pred_taken", k), {31'd0, pred_taken}, {31'd0, vecs[k].et});
         check($sformatf("vec%0d pred_target", k), pred_target, vecs[k].etg);
      end

      // Reset asserted mid-cycle must clear outputs at once and empty the table.
      drive(0, 0, 1, 'h800, 'h880, 1, 0);
      drive(1, 'h800, 0, 0, 0, 0, 0);
      check("pre-reset hit", {31'd0, hit}, 1);
      #2;
      arst_n = 1'b0;
      #1;
      check("async reset hit", {31'd0, hit}, 0);
      check("async reset pred_taken", {31'd0, pred_taken}, 0);
      check("async reset pred_target", pred_target, 0);
      @(negedge clk);
      arst_n = 1'b1;
      model_reset();
      drive(1, 'h800, 0, 0, 0, 0, 0);
      check("post-reset hit", {31'd0, hit}, 0);
      check("post-reset pred_target", pred_target, 'h804);

      for (int k = 0; k < 600; k++) begin
         logic        lk, uv, ut, inv;
         logic [31:0] a, ua, tg;
         lk  = ($urandom_range(0, 3) != 0);
         a   = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
         uv  = ($urandom_range(0, 1) != 0);
         ua  = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
         ut  = ($urandom_range(0, 9) < 6);
         tg  = $urandom;
         inv = ($urandom_range(0, 63) == 0);
         drive(lk, a, uv, ua, tg, ut, inv);
         check("rand hit", {31'd0, hit}, {31'd0, e_hit});
         check("rand pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
         check("rand pred_target", pred_target, e_tgt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
